led_pattern_arbiter: RTL and testbench
======================================

# led_pattern_arbiter

Shares the two board status LEDs (TEACHEE_LED0/TEACHEE_LED1) between up to NUM_REQ independent requesters (firmware status, link activity, error monitors) using a request/grant handshake and round-robin arbitration. The granted requester's 2-bit pattern code drives the LEDs for a fixed number of blink phases. Blink phases are timed from sysclk by an internal phase timer. The block sits at the top level between the status sources and the LED pins, and replaces free-running blink counters.

## Interface
- NUM_REQ, 4: number of requesters; legal range 2..8.
- PHASE_CYCLES, 6000000: sysclk cycles per blink phase; must be at least 2.
- HOLD_PHASES, 4: phases a grant is held; must be at least 1.
- sysclk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request level.
- pattern  in  NUM_REQ x 2  per-requester code: 00 off, 01 solid, 10 blink, 11 alternate.
- grant  out  NUM_REQ  one-hot registered grant; all-zero when idle.
- busy  out  1  high whenever state is not IDLE.
- TEACHEE_LED0  out  1  LED 0 drive.
- TEACHEE_LED1  out  1  LED 1 drive.

## Operation
- FSM states: IDLE, SHOW, GAP. GAP exists only with the macro defined.
- IDLE: LEDs 0, grant 0.
  - If any req bit is high, choose the first set bit at or after rr_ptr, wrapping modulo NUM_REQ.
  - Register the one-hot grant and latch that requester's pattern.
  - Next state SHOW. Clear the phase counter, phase_state and hold counter.
- SHOW: LEDs driven from the latched pattern and phase_state.
  - 00: both LEDs 0.
  - 01: both LEDs 1.
  - 10: both LEDs = phase_state.
  - 11: LED0 = phase_state, LED1 = ~phase_state.
- Phase timer: counter runs 0..PHASE_CYCLES-1.
  - At PHASE_CYCLES-1 it asserts phase_tick for one cycle, wraps to 0 and toggles phase_state.
- Each phase_tick in SHOW increments the hold counter.
- Grant ends on the phase_tick that brings the hold counter to HOLD_PHASES.
- Grant also ends early on the first phase_tick at which the granted req bit is low. Deassertion mid-phase does not shorten the current phase.
- On grant end: rr_ptr = granted index + 1 (mod NUM_REQ), grant cleared, next state IDLE, or GAP with the macro defined.
- Pattern input changes during SHOW are ignored; the code latched at grant is used.
- Requests arriving during SHOW/GAP wait. req is level-sensitive; no request is queued beyond its level.
- Simultaneous requests: round-robin order from rr_ptr.
- A requester that holds req continuously is re-granted only after every other active requester has been served.
- Reset: state IDLE, rr_ptr 0, all counters 0, phase_state 0, grant 0, busy 0, both LEDs 0. Reset applies from any state and overrides phase_tick in the same cycle.
- Widths: phase counter $clog2(PHASE_CYCLES); hold counter $clog2(HOLD_PHASES+1); rr_ptr $clog2(NUM_REQ). Wrap uses explicit compare, not natural overflow.

## Timing
- req high in IDLE at cycle N: grant and busy high at N+1, LEDs showing the pattern at N+1.
- A SHOW grant lasts exactly HOLD_PHASES*PHASE_CYCLES cycles if req stays high.
- grant falls in the cycle after the terminating phase_tick.
- From the IDLE re-entry cycle, the earliest next grant is one cycle later: one idle cycle between grants. With the GAP state, the gap is PHASE_CYCLES+1 cycles.
- All outputs are registered; no combinational path from req or pattern to outputs.

## Configuration
- LED_ARB_GAP_EN defined: GAP state inserted after each grant. It lasts one full phase (PHASE_CYCLES cycles) with LEDs 0, grant 0 and busy 1, then goes to IDLE. This makes hand-offs visible on the board.
- LED_ARB_GAP_EN undefined: SHOW returns directly to IDLE. The GAP encoding is absent.

## Structure
- Package led_arb_pkg holds:
  - the pattern code enum (PAT_OFF, PAT_SOLID, PAT_BLINK, PAT_ALT), 2 bits;
  - the state enum;
  - the parameter legality limits.
- Sub-module led_phase_timer holds the phase counter, phase_tick and phase_state. It has a synchronous clear input, driven on grant, and the PHASE_CYCLES parameter.
- The top module holds the FSM, round-robin pick, hold counter and LED output registers.

## Test plan
All cases use NUM_REQ=4, PHASE_CYCLES=4, HOLD_PHASES=2.
- Reset: assert reset for 3 cycles with req=4'b1111 -> grant 0, busy 0, LEDs 00 throughout; first grant 4'b0001 one cycle after reset drops.
- Single requester: req[2]=1, pattern[2]=11 -> grant 4'b0100 for 8 cycles. LED0/LED1 = 0/1 for 4 cycles, then 1/0 for 4 cycles, then grant 0 and LEDs 00.
- Round-robin: req=4'b1011 held -> grant sequence 0001, 0010, 1000, 0001. Each grant lasts 8 cycles, separated by 1 idle cycle (5 with LED_ARB_GAP_EN).
- Early release: req[1] drops 2 cycles into the grant -> grant ends at the first phase_tick (cycle 4 of SHOW), not at 8.
- Pattern latch: pattern[0] changes 01 to 00 mid-grant -> LEDs stay 11 until the grant ends.
- Reset mid-SHOW: reset in cycle 5 of a grant -> next cycle grant 0, LEDs 00, rr_ptr 0; the following grant starts from requester 0.

Source files
------------

// File: rtl/led_arb_pkg.sv
// Shared types and helpers for the LED pattern arbiter.
// LED_ARB_GAP_EN adds the GAP state to the state encoding.
package led_arb_pkg;

  localparam int NUM_REQ_MIN      = 2;
  localparam int NUM_REQ_MAX      = 8;
  localparam int PHASE_CYCLES_MIN = 2;
  localparam int HOLD_PHASES_MIN  = 1;

  typedef enum logic [1:0] {
    PAT_OFF   = 2'b00,
    PAT_SOLID = 2'b01,
    PAT_BLINK = 2'b10,
    PAT_ALT   = 2'b11
  } pat_e;

`ifdef LED_ARB_GAP_EN
  typedef enum logic [1:0] {ST_IDLE, ST_SHOW, ST_GAP} state_e;
`else
  typedef enum logic {ST_IDLE, ST_SHOW} state_e;
`endif

  // Returns {LED1, LED0} for a pattern code at the given blink phase.
  function automatic logic [1:0] led_drive(pat_e p, logic ps);
    case (p)
      PAT_OFF:   return 2'b00;
      PAT_SOLID: return 2'b11;
      PAT_BLINK: return {ps, ps};
      PAT_ALT:   return {~ps, ps};
      default:   return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/led_phase_timer.sv
// Blink phase timer: counts PHASE_CYCLES sysclk cycles per phase and
// toggles phase_state at each wrap. Clear restarts phase 0 at a grant.
module led_phase_timer
  import led_arb_pkg::*;
#(
  parameter int PHASE_CYCLES = 6000000
) (
  input  logic sysclk,
  input  logic reset,
  input  logic clear,
  output logic phase_tick,
  output logic phase_state
);

  localparam int CW = $clog2(PHASE_CYCLES);

  logic [CW-1:0] cnt;

  assign phase_tick = (cnt == CW'(PHASE_CYCLES - 1));

  always_ff @(posedge sysclk) begin
    if (reset || clear) begin
      cnt         <= '0;
      phase_state <= 1'b0;
    end else if (phase_tick) begin
      cnt         <= '0;
      phase_state <= ~phase_state;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_pattern_arbiter.sv
// Round-robin arbiter sharing the two status LEDs between NUM_REQ requesters.
// Define LED_ARB_GAP_EN to insert a one-phase dark GAP after every grant.
module led_pattern_arbiter
  import led_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int PHASE_CYCLES = 6000000,
  parameter int HOLD_PHASES  = 4
) (
  input  logic                    sysclk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ-1:0][1:0] pattern,
  output logic [NUM_REQ-1:0]      grant,
  output logic                    busy,
  output logic                    TEACHEE_LED0,
  output logic                    TEACHEE_LED1
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int HW = $clog2(HOLD_PHASES + 1);

  if (NUM_REQ < NUM_REQ_MIN || NUM_REQ > NUM_REQ_MAX ||
      PHASE_CYCLES < PHASE_CYCLES_MIN || HOLD_PHASES < HOLD_PHASES_MIN) begin : g_bad_param
    $error("led_pattern_arbiter: parameter out of legal range");
  end

  state_e        state;
  logic [PW-1:0] rr_ptr, gnt_idx, pick;
  logic          pick_vld;
  logic [PW:0]   cand;
  logic [HW-1:0] hold_cnt;
  pat_e          pat_q;
  logic [1:0]    leds;
  logic          tick, phase_state, clear, last_phase;
  logic [PW-1:0] ptr_next;

  // First set request at or after rr_ptr, wrapping by explicit compare.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr} + (PW+1)'(i);
      if (cand >= (PW+1)'(NUM_REQ)) cand = cand - (PW+1)'(NUM_REQ);
      if (!pick_vld && req[cand[PW-1:0]]) begin
        pick_vld = 1'b1;
        pick     = cand[PW-1:0];
      end
    end
  end

  assign clear      = (state == ST_IDLE) && pick_vld;
  assign last_phase = (hold_cnt == HW'(HOLD_PHASES - 1)) || !req[gnt_idx];
  assign ptr_next   = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  led_phase_timer #(.PHASE_CYCLES(PHASE_CYCLES)) u_timer (
    .sysclk      (sysclk),
    .reset       (reset),
    .clear       (clear),
    .phase_tick  (tick),
    .phase_state (phase_state)
  );

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      gnt_idx  <= '0;
      grant    <= '0;
      busy     <= 1'b0;
      hold_cnt <= '0;
      pat_q    <= PAT_OFF;
      leds     <= 2'b00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            state    <= ST_SHOW;
            busy     <= 1'b1;
            grant    <= NUM_REQ'(1) << pick;
            gnt_idx  <= pick;
            pat_q    <= pat_e'(pattern[pick]);
            hold_cnt <= '0;
            leds     <= led_drive(pat_e'(pattern[pick]), 1'b0);
          end
        end
        ST_SHOW: begin
          if (tick) begin
            if (last_phase) begin
              grant    <= '0;
              leds     <= 2'b00;
              hold_cnt <= '0;
              rr_ptr   <= ptr_next;
`ifdef LED_ARB_GAP_EN
              state    <= ST_GAP;
`else
              state    <= ST_IDLE;
              busy     <= 1'b0;
`endif
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
              // LEDs lead the timer by one cycle so they match the new phase.
              leds     <= led_drive(pat_q, ~phase_state);
            end
          end
        end
`ifdef LED_ARB_GAP_EN
        ST_GAP: begin
          if (tick) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign TEACHEE_LED0 = leds[0];
  assign TEACHEE_LED1 = leds[1];

endmodule

// File: tb/tb_led_pattern_arbiter.sv
// Bench for led_pattern_arbiter: directed scenarios with literal expectations
// plus randomized traffic against a grant-level behavioural model.
module tb_led_pattern_arbiter;

  localparam int N    = 4;
  localparam int PC   = 4;
  localparam int HOLD = 2;
`ifdef LED_ARB_GAP_EN
  localparam int GAP = PC;
`else
  localparam int GAP = 0;
`endif

  logic              sysclk = 1'b0;
  logic              reset  = 1'b1;
  logic [N-1:0]      req    = '0;
  logic [N-1:0][1:0] pattern = '0;
  logic [N-1:0]      grant;
  logic              busy, led0, led1;

  led_pattern_arbiter #(.NUM_REQ(N), .PHASE_CYCLES(PC), .HOLD_PHASES(HOLD)) dut (
    .sysclk       (sysclk),
    .reset        (reset),
    .req          (req),
    .pattern      (pattern),
    .grant        (grant),
    .busy         (busy),
    .TEACHEE_LED0 (led0),
    .TEACHEE_LED1 (led1)
  );

  always #5 sysclk = ~sysclk;

  // Model: who owns the LEDs, how many cycles into the grant, gap cycles left.
  int         m_own = -1, m_k = 0, m_gap = 0, m_ptr = 0;
  logic [1:0] m_pat = 2'b00;
  bit         model_ok = 1'b0;

  always @(posedge sysclk) begin
    if (reset) begin
      m_own = -1; m_k = 0; m_gap = 0; m_ptr = 0; model_ok = 1'b1;
    end else if (m_own >= 0) begin
      if ((m_k % PC == PC - 1) && (((m_k + 1) / PC >= HOLD) || !req[m_own])) begin
        m_ptr = (m_own + 1) % N;
        m_own = -1;
        m_gap = GAP;
      end else begin
        m_k++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (req != '0) begin
      for (int i = 0; i < N; i++)
        if (m_own < 0 && req[(m_ptr + i) % N]) m_own = (m_ptr + i) % N;
      m_k   = 0;
      m_pat = pattern[m_own];
    end
  end

  function automatic logic [1:0] model_leds(int own, int k, logic [1:0] p);
    logic ph;
    ph = logic'((k / PC) % 2);
    if (own < 0) return 2'b00;
    case (p)
      2'b00:   return 2'b00;
      2'b01:   return 2'b11;
      2'b10:   return {ph, ph};
      default: return {~ph, ph};
    endcase
  endfunction

  int         vectors = 0, miscompares = 0;
  bit         lit_en = 1'b0;
  string      lit_name = "";
  logic [3:0] lit_grant = '0;
  logic [1:0] lit_leds = '0;
  logic       lit_busy = 1'b0;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Single compare process: model every cycle, literal expectations when armed.
  always @(negedge sysclk) begin
    if (model_ok) begin
      check("model_grant", 8'(grant), (m_own >= 0) ? 8'(1 << m_own) : 8'h00);
      check("model_busy", 8'(busy), 8'((m_own >= 0) || (m_gap > 0)));
      check("model_leds", 8'({led1, led0}), 8'(model_leds(m_own, m_k, m_pat)));
      if (lit_en) begin
        check({lit_name, "_grant"}, 8'(grant), 8'(lit_grant));
        check({lit_name, "_leds"}, 8'({led1, led0}), 8'(lit_leds));
        check({lit_name, "_busy"}, 8'(busy), 8'(lit_busy));
      end
    end
  end

  task automatic cyc();
    @(posedge sysclk);
    #2;
    lit_en = 1'b0;
  endtask

  task automatic expect_lit(input string nm, input logic [3:0] g, input logic [1:0] l, input logic b);
    lit_name = nm; lit_grant = g; lit_leds = l; lit_busy = b; lit_en = 1'b1;
  endtask

  // Pulse reset, then raise req; returns in cycle 1 of the resulting grant.
  task automatic start(input logic [3:0] r);
    reset = 1'b1; cyc();
    reset = 1'b0; req = r; cyc();
  endtask

  logic [3:0] seq [4];
  int         pos, n, waited;

  initial begin
    seq = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};

    // Reset held with all requests high.
    req = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      cyc(); expect_lit("reset_hold", 4'b0000, 2'b00, 1'b0);
    end
    reset = 1'b0;
    cyc(); expect_lit("first_grant", 4'b0001, 2'b00, 1'b1);

    // Single requester, alternate pattern.
    req = '0; pattern = '0; pattern[2] = 2'b11;
    start(4'b0100);
    for (int c = 1; c <= 8; c++) begin
      expect_lit("single", 4'b0100, (c <= 4) ? 2'b10 : 2'b01, 1'b1);
      cyc();
    end
    expect_lit("single_end", 4'b0000, 2'b00, GAP > 0);

    // Round-robin with req=1011 held.
    pattern = {4{2'b01}};
    start(4'b1011);
    for (int t = 1; t <= 4 * (8 + 1 + GAP); t++) begin
      pos = (t - 1) % (8 + 1 + GAP);
      n   = (t - 1) / (8 + 1 + GAP);
      expect_lit("rr", (pos < 8) ? seq[n] : 4'b0000, (pos < 8) ? 2'b11 : 2'b00, pos < 8 + GAP);
      cyc();
    end

    // Early release: req[1] drops in cycle 2, grant ends at the first phase tick.
    start(4'b0010);
    expect_lit("early", 4'b0010, 2'b11, 1'b1); cyc();
    req = '0;
    for (int c = 2; c <= 4; c++) begin
      expect_lit("early", 4'b0010, 2'b11, 1'b1); cyc();
    end
    expect_lit("early_end", 4'b0000, 2'b00, GAP > 0); cyc();

    // Pattern latched at grant.
    pattern = {4{2'b01}};
    start(4'b0001);
    for (int c = 1; c <= 8; c++) begin
      if (c == 3) pattern[0] = 2'b00;
      expect_lit("latch", 4'b0001, 2'b11, 1'b1);
      cyc();
    end
    expect_lit("latch_end", 4'b0000, 2'b00, GAP > 0); cyc();

    // Reset in cycle 5 of a grant restarts round-robin from requester 0.
    pattern = {4{2'b01}};
    start(4'b0100);
    for (int c = 1; c <= 8; c++) cyc();
    req = 4'b1111;
    waited = 0;
    while (grant == '0 && waited < 40) begin
      cyc(); waited++;
    end
    expect_lit("rr_after_hold", 4'b1000, 2'b11, 1'b1);
    for (int c = 1; c <= 4; c++) cyc();
    reset = 1'b1;
    cyc(); expect_lit("mid_reset", 4'b0000, 2'b00, 1'b0);
    reset = 1'b0;
    cyc(); expect_lit("post_reset", 4'b0001, 2'b11, 1'b1);
    cyc();

    // Randomized traffic, checked against the model only.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) req = 4'($urandom);
      pattern = 8'($urandom);
      reset   = ($urandom_range(199) == 0);
      cyc();
    end
    reset = 1'b0;
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
